// File: rtl/riscv_isa_pkg.sv
// Shared ISA-level types for the rp core: access sizes and LSU FSM states.
package riscv_isa_pkg;

  localparam int unsigned DSW = 4;

  typedef enum logic [1:0] {
    SIZ_B = 2'd0,
    SIZ_H = 2'd1,
    SIZ_W = 2'd2
  } lsu_siz_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/rp_lsu_align.sv
// Byte-lane steering for the LSU: select/replicated write data, alignment
// check, and load lane extraction with sign/zero extension.
module rp_lsu_align
  import riscv_isa_pkg::*;
(
  input  logic [1:0]     adr_lo,
  input  logic [1:0]     siz,
  input  logic           uns,
  input  logic [31:0]    wdt,
  input  logic [31:0]    rdt,
  output logic [DSW-1:0] sel_c,
  output logic [31:0]    wdt_c,
  output logic           mis_c,
  output logic [31:0]    rdt_c
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdt[{adr_lo, 3'b000} +: 8];
  assign lane_h = rdt[{adr_lo[1], 4'b0000} +: 16];

  always_comb begin
    sel_c = '0;
    wdt_c = '0;
    mis_c = 1'b0;
    rdt_c = '0;
    case (siz)
      SIZ_B: begin
        sel_c = 4'b0001 << adr_lo;
        wdt_c = {4{wdt[7:0]}};
        rdt_c = uns ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SIZ_H: begin
        mis_c = adr_lo[0];
        sel_c = 4'b0011 << adr_lo;
        wdt_c = {2{wdt[15:0]}};
        rdt_c = uns ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      SIZ_W: begin
        mis_c = |adr_lo;
        sel_c = 4'b1111;
        wdt_c = wdt;
        rdt_c = rdt;
      end
      default: mis_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/rp_lsu.sv
// Load/store unit: zero-wait bus access from IDLE, otherwise captures the
// request and holds the bus in WAIT until ack or optional timeout.
module rp_lsu
  import riscv_isa_pkg::*;
#(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned TMO = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ls_req,
  input  logic           ls_wen,
  input  logic [AW-1:0]  ls_adr,
  input  logic [1:0]     ls_siz,
  input  logic           ls_uns,
  input  logic [DW-1:0]  ls_wdt,
  output logic [DW-1:0]  ls_rdt,
  output logic           ls_vld,
  output logic           ls_stl,
  output logic           ls_mis,
  output logic           ls_err,
  output logic           bud_req,
  output logic           bud_wen,
  output logic [AW-1:0]  bud_adr,
  output logic [DSW-1:0] bud_sel,
  output logic [DW-1:0]  bud_wdt,
  input  logic [DW-1:0]  bud_rdt,
  input  logic           bud_ack
);

  localparam int unsigned CW = (TMO > 1) ? $clog2(TMO) : 1;

  lsu_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           wen_q, wen_d;
  logic [AW-1:0]  adr_q, adr_d;
  logic [1:0]     siz_q, siz_d;
  logic           uns_q, uns_d;
  logic [DSW-1:0] sel_q, sel_d;
  logic [DW-1:0]  wdt_q, wdt_d;

  logic           in_wait;
  logic [1:0]     al_adr;
  logic [1:0]     al_siz;
  logic           al_uns;
  logic [DSW-1:0] al_sel;
  logic [DW-1:0]  al_wdt;
  logic           al_mis;
  logic [DW-1:0]  al_rdt;
  logic           tmo_hit;

  // Lane logic follows the live request in IDLE and the captured one in WAIT.
  assign in_wait = (state_q == WAIT);
  assign al_adr  = in_wait ? adr_q[1:0] : ls_adr[1:0];
  assign al_siz  = in_wait ? siz_q : ls_siz;
  assign al_uns  = in_wait ? uns_q : ls_uns;
  assign tmo_hit = (TMO != 0) && (cnt_q == CW'(TMO - 1));

  rp_lsu_align u_align (
    .adr_lo (al_adr),
    .siz    (al_siz),
    .uns    (al_uns),
    .wdt    (ls_wdt),
    .rdt    (bud_rdt),
    .sel_c  (al_sel),
    .wdt_c  (al_wdt),
    .mis_c  (al_mis),
    .rdt_c  (al_rdt)
  );

  // Next state, capture and bus/core outputs; everything is forced quiet during reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    adr_d   = adr_q;
    siz_d   = siz_q;
    uns_d   = uns_q;
    sel_d   = sel_q;
    wdt_d   = wdt_q;
    ls_rdt  = '0;
    ls_vld  = 1'b0;
    ls_stl  = 1'b0;
    ls_mis  = 1'b0;
    ls_err  = 1'b0;
    bud_req = 1'b0;
    bud_wen = 1'b0;
    bud_adr = '0;
    bud_sel = '0;
    bud_wdt = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (ls_req) begin
            if (al_mis) begin
              ls_mis = 1'b1;
            end else begin
              bud_req = 1'b1;
              bud_wen = ls_wen;
              bud_adr = {ls_adr[AW-1:2], 2'b00};
              bud_sel = al_sel;
              bud_wdt = al_wdt;
              if (bud_ack) begin
                ls_vld = 1'b1;
                ls_rdt = ls_wen ? '0 : al_rdt;
              end else begin
                ls_stl  = 1'b1;
                state_d = WAIT;
                cnt_d   = '0;
                wen_d   = ls_wen;
                adr_d   = ls_adr;
                siz_d   = ls_siz;
                uns_d   = ls_uns;
                sel_d   = al_sel;
                wdt_d   = al_wdt;
              end
            end
          end
        end
        WAIT: begin
          bud_req = 1'b1;
          bud_wen = wen_q;
          bud_adr = {adr_q[AW-1:2], 2'b00};
          bud_sel = sel_q;
          bud_wdt = wdt_q;
          if (bud_ack) begin
            ls_vld  = 1'b1;
            ls_rdt  = wen_q ? '0 : al_rdt;
            state_d = IDLE;
          end else if (tmo_hit) begin
            ls_err  = 1'b1;
            state_d = IDLE;
          end else begin
            ls_stl = 1'b1;
            cnt_d  = cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      siz_q   <= '0;
      uns_q   <= 1'b0;
      sel_q   <= '0;
      wdt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      adr_q   <= adr_d;
      siz_q   <= siz_d;
      uns_q   <= uns_d;
      sel_q   <= sel_d;
      wdt_q   <= wdt_d;
    end
  end

endmodule

// File: tb/tb_rp_lsu.sv
// Self-checking bench for rp_lsu (TMO = 8): directed cases plus random
// accesses checked against a transaction-level model.
module tb_rp_lsu;

  logic        clk;
  logic        rst;
  logic        ls_req;
  logic        ls_wen;
  logic [31:0] ls_adr;
  logic [1:0]  ls_siz;
  logic        ls_uns;
  logic [31:0] ls_wdt;
  logic [31:0] ls_rdt;
  logic        ls_vld;
  logic        ls_stl;
  logic        ls_mis;
  logic        ls_err;
  logic        bud_req;
  logic        bud_wen;
  logic [31:0] bud_adr;
  logic [3:0]  bud_sel;
  logic [31:0] bud_wdt;
  logic [31:0] bud_rdt;
  logic        bud_ack;

  int checks = 0;
  int errors = 0;

  logic [3:0]  last_sel;
  logic [31:0] last_wdt;
  logic [31:0] last_adr;
  logic [31:0] last_rdt;
  int          last_stalls;

  rp_lsu #(.AW(32), .DW(32), .TMO(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .ls_req  (ls_req),
    .ls_wen  (ls_wen),
    .ls_adr  (ls_adr),
    .ls_siz  (ls_siz),
    .ls_uns  (ls_uns),
    .ls_wdt  (ls_wdt),
    .ls_rdt  (ls_rdt),
    .ls_vld  (ls_vld),
    .ls_stl  (ls_stl),
    .ls_mis  (ls_mis),
    .ls_err  (ls_err),
    .bud_req (bud_req),
    .bud_wen (bud_wen),
    .bud_adr (bud_adr),
    .bud_sel (bud_sel),
    .bud_wdt (bud_wdt),
    .bud_rdt (bud_rdt),
    .bud_ack (bud_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access width in bytes is 2**siz, natural alignment required.
  function automatic logic m_mis(input logic [31:0] adr, input logic [1:0] siz);
    int n;
    if (siz == 2'd3) return 1'b1;
    n = 1 << siz;
    return (adr % n) != 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [31:0] adr, input logic [1:0] siz);
    int n;
    n = 1 << siz;
    return 4'(((1 << n) - 1) << (adr % 4));
  endfunction

  function automatic logic [31:0] m_wdt(input logic [31:0] wdt, input logic [1:0] siz);
    int n;
    longint v;
    longint r;
    n = 1 << siz;
    v = wdt & ((64'd1 << (8 * n)) - 1);
    r = 0;
    for (int i = 0; i < 4 / n; i++) r = r | (v << (8 * n * i));
    return 32'(r);
  endfunction

  function automatic logic [31:0] m_rdt(input logic wen, input logic [31:0] adr,
                                        input logic [1:0] siz, input logic uns,
                                        input logic [31:0] rdt);
    int n;
    longint v;
    if (wen) return 32'h0;
    n = 1 << siz;
    v = (rdt >> (8 * (adr % 4))) & ((64'd1 << (8 * n)) - 1);
    if (!uns && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return 32'(v);
  endfunction

  // One access with ack after lat wait cycles (0 = same cycle); ends one idle cycle later.
  task automatic do_access(input logic wen, input logic [31:0] adr, input logic [1:0] siz,
                           input logic uns, input logic [31:0] wdt, input logic [31:0] rdt,
                           input int lat);
    logic        mis_e;
    logic [3:0]  sel_e;
    logic [31:0] wdt_e;
    logic [31:0] rdt_e;
    logic [31:0] adr_e;
    int          stalls;
    mis_e = m_mis(adr, siz);
    sel_e = m_sel(adr, siz);
    wdt_e = m_wdt(wdt, siz);
    rdt_e = m_rdt(wen, adr, siz, uns, rdt);
    adr_e = {adr[31:2], 2'b00};
    ls_req = 1'b1; ls_wen = wen; ls_adr = adr; ls_siz = siz; ls_uns = uns; ls_wdt = wdt;
    bud_rdt = rdt; bud_ack = (lat == 0);
    @(negedge clk);
    chk("acc_mis", ls_mis, mis_e);
    chk("acc_err", ls_err, 0);
    if (mis_e) begin
      chk("mis_req", bud_req, 0);
      chk("mis_stl", ls_stl, 0);
      chk("mis_vld", ls_vld, 0);
    end else begin
      chk("acc_req", bud_req, 1);
      chk("acc_wen", bud_wen, wen);
      chk("acc_adr", bud_adr, adr_e);
      chk("acc_sel", bud_sel, sel_e);
      chk("acc_wdt", bud_wdt, wdt_e);
      chk("acc_stl", ls_stl, lat != 0);
      chk("acc_vld", ls_vld, lat == 0);
      last_sel = bud_sel; last_wdt = bud_wdt; last_adr = bud_adr;
      stalls = ls_stl;
      if (lat == 0) begin
        chk("acc_rdt", ls_rdt, rdt_e);
        last_rdt = ls_rdt;
      end
      for (int k = 1; k <= lat; k++) begin
        @(posedge clk); #1;
        ls_req = 1'($urandom); ls_wen = 1'($urandom); ls_adr = $urandom;
        ls_siz = 2'($urandom); ls_uns = 1'($urandom); ls_wdt = $urandom;
        bud_ack = (k == lat);
        bud_rdt = (k == lat) ? rdt : $urandom;
        @(negedge clk);
        chk("wait_req", bud_req, 1);
        chk("wait_wen", bud_wen, wen);
        chk("wait_adr", bud_adr, adr_e);
        chk("wait_sel", bud_sel, sel_e);
        chk("wait_wdt", bud_wdt, wdt_e);
        chk("wait_mis", ls_mis, 0);
        chk("wait_err", ls_err, 0);
        chk("wait_stl", ls_stl, k != lat);
        chk("wait_vld", ls_vld, k == lat);
        stalls += int'(ls_stl);
        if (k == lat) begin
          chk("wait_rdt", ls_rdt, rdt_e);
          last_rdt = ls_rdt;
        end
      end
      chk("stall_cnt", 32'(stalls), 32'(lat));
      last_stalls = stalls;
    end
    @(posedge clk); #1;
    ls_req = 1'b0; bud_ack = 1'b0;
    @(negedge clk);
    chk("post_req", bud_req, 0);
    chk("post_stl", ls_stl, 0);
    chk("post_vld", ls_vld, 0);
    @(posedge clk); #1;
  endtask

  // Load left unacked until the 8th WAIT cycle; ack_last acks exactly on that cycle.
  task automatic tmo_run(input logic ack_last);
    ls_req = 1'b1; ls_wen = 1'b0; ls_adr = 32'h4000; ls_siz = 2'd2; ls_uns = 1'b0;
    bud_ack = 1'b0; bud_rdt = 32'h89ABCDEF;
    @(negedge clk);
    chk("tmo_first_stl", ls_stl, 1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      ls_req = 1'b0;
      bud_ack = ack_last && (k == 8);
      @(negedge clk);
      chk("tmo_req", bud_req, 1);
      chk("tmo_err", ls_err, !ack_last && (k == 8));
      chk("tmo_stl", ls_stl, k != 8);
      chk("tmo_vld", ls_vld, ack_last && (k == 8));
      if (ack_last && k == 8) chk("tmo_rdt", ls_rdt, 32'h89ABCDEF);
    end
    @(posedge clk); #1;
    bud_ack = 1'b0;
    @(negedge clk);
    chk("tmo_idle_req", bud_req, 0);
    chk("tmo_idle_err", ls_err, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0]  r_siz;
    logic [31:0] r_adr;
    rst = 1'b1; ls_req = 1'b0; ls_wen = 1'b0; ls_adr = '0; ls_siz = '0; ls_uns = 1'b0;
    ls_wdt = '0; bud_rdt = '0; bud_ack = 1'b0;
    last_sel = '0; last_wdt = '0; last_adr = '0; last_rdt = '0; last_stalls = 0;

    @(negedge clk);
    chk("rst_req", bud_req, 0);
    chk("rst_wen", bud_wen, 0);
    chk("rst_sel", bud_sel, 0);
    chk("rst_adr", bud_adr, 0);
    chk("rst_wdt", bud_wdt, 0);
    chk("rst_vld", ls_vld, 0);
    chk("rst_stl", ls_stl, 0);
    chk("rst_mis", ls_mis, 0);
    chk("rst_err", ls_err, 0);
    chk("rst_rdt", ls_rdt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_access(1'b1, 32'h1000, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 0);
    chk("sw_sel", 32'(last_sel), 32'hF);
    chk("sw_adr", last_adr, 32'h1000);
    chk("sw_wdt", last_wdt, 32'hDEADBEEF);
    chk("sw_stalls", 32'(last_stalls), 0);

    do_access(1'b1, 32'h1003, 2'd0, 1'b0, 32'h000000A5, 32'h0, 3);
    chk("sb_sel", 32'(last_sel), 32'h8);
    chk("sb_wdt", last_wdt, 32'hA5A5A5A5);
    chk("sb_stalls", 32'(last_stalls), 3);

    do_access(1'b0, 32'h2002, 2'd0, 1'b0, 32'h0, 32'h12F03456, 0);
    chk("lb_rdt", last_rdt, 32'hFFFFFFF0);
    do_access(1'b0, 32'h2002, 2'd0, 1'b1, 32'h0, 32'h12F03456, 0);
    chk("lbu_rdt", last_rdt, 32'h000000F0);
    do_access(1'b0, 32'h2002, 2'd1, 1'b0, 32'h0, 32'h12F03456, 0);
    chk("lh_rdt", last_rdt, 32'h000012F0);
    do_access(1'b0, 32'h2002, 2'd1, 1'b0, 32'h0, 32'h12F03456, 2);
    chk("lh_wait_rdt", last_rdt, 32'h000012F0);
    do_access(1'b0, 32'h2001, 2'd0, 1'b0, 32'h0, 32'h12F08456, 1);
    chk("lb_wait_rdt", last_rdt, 32'hFFFFFF84);

    do_access(1'b0, 32'h3002, 2'd2, 1'b0, 32'h0, 32'h0, 0);
    do_access(1'b0, 32'h3000, 2'd3, 1'b0, 32'h0, 32'h0, 0);
    do_access(1'b1, 32'h3003, 2'd3, 1'b0, 32'h0, 32'h0, 0);
    do_access(1'b1, 32'h3001, 2'd1, 1'b0, 32'h0, 32'h0, 0);

    tmo_run(1'b0);
    tmo_run(1'b1);

    // Asynchronous reset while waiting on a load.
    ls_req = 1'b1; ls_wen = 1'b0; ls_adr = 32'h5000; ls_siz = 2'd2; ls_uns = 1'b0;
    bud_ack = 1'b0; bud_rdt = 32'h11223344;
    @(posedge clk); #1;
    ls_req = 1'b0;
    @(posedge clk); #1;
    chk("prerst_req", bud_req, 1);
    bud_ack = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("arst_req", bud_req, 0);
    chk("arst_vld", ls_vld, 0);
    chk("arst_stl", ls_stl, 0);
    @(posedge clk); #1;
    rst = 1'b0; bud_ack = 1'b0;
    @(negedge clk);
    chk("arst_idle_req", bud_req, 0);
    @(posedge clk); #1;
    do_access(1'b0, 32'h5004, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 1);
    chk("arst_lw_rdt", last_rdt, 32'hCAFEF00D);

    for (int i = 0; i < 40; i++) begin
      r_siz = 2'($urandom_range(0, 3));
      r_adr = $urandom;
      if ($urandom_range(0, 3) != 0 && r_siz != 2'd3)
        r_adr = r_adr & ~((32'd1 << r_siz) - 32'd1);
      do_access(1'($urandom), r_adr, r_siz, 1'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
